// File: rtl/guarded_counter_checker.sv
// Checks guarded counter samples: even/odd popcount guards and, with CHECKER_SEQ_EN
// defined, the +1 sequence. Reports error pulses, a saturating error count and a sticky fault.
module guarded_counter_checker #(
  parameter int WIDTH      = 8,
  parameter int GUARD_BITS = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int MAX_MISS   = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic [GUARD_BITS-1:0] even_in,
  input  logic [GUARD_BITS-1:0] odd_in,
  output logic                  parity_err,
  output logic                  seq_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  fault,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'b00,
    ST_TRACK   = 2'b01,
    ST_FAULT   = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             miss_q, miss_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   parity_err_q, parity_err_d;
  logic                   seq_err_q, seq_err_d;
  logic                   fault_q, fault_d;
  logic [GUARD_BITS-1:0]  pe, po;
  logic                   par_mis, seq_mis, bad;

  // Guard-width accumulation gives the modulo 2^GUARD_BITS truncation for free.
  always_comb begin
    pe = '0;
    po = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i % 2 == 0) pe = pe + GUARD_BITS'(cnt_in[i]);
      else            po = po + GUARD_BITS'(cnt_in[i]);
    end
  end

  assign par_mis = (pe != even_in) || (po != odd_in);

`ifdef CHECKER_SEQ_EN
  logic [WIDTH-1:0] expected_q, expected_d;

  assign seq_mis = (state_q != ST_ACQUIRE) && (cnt_in != expected_q);

  // Advancing from the prediction rather than the sample limits a corrupted value to one seq_err.
  always_comb begin
    expected_d = expected_q;
    if (in_valid) begin
      if (state_q == ST_ACQUIRE) expected_d = cnt_in + WIDTH'(1);
      else                       expected_d = expected_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      expected_q <= '0;
    else if (clr)   expected_q <= '0;
    else            expected_q <= expected_d;
  end
`else
  assign seq_mis = 1'b0;
`endif

  assign bad = in_valid && (par_mis || seq_mis);

  always_comb begin
    state_d      = state_q;
    miss_d       = miss_q;
    err_cnt_d    = err_cnt_q;
    parity_err_d = in_valid && par_mis;
    seq_err_d    = in_valid && seq_mis;

    if (bad) begin
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      if (miss_q != 4'hF)                 miss_d    = miss_q + 4'd1;
    end else if (in_valid && state_q == ST_TRACK) begin
      miss_d = '0;
    end

    case (state_q)
      ST_ACQUIRE: if (in_valid) state_d = ST_TRACK;
      ST_TRACK: begin
        // >= also covers a miss already carried in from a bad seeding sample.
        if (bad && ({1'b0, miss_q} + 5'd1) >= 5'(MAX_MISS)) state_d = ST_FAULT;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_ACQUIRE;
    endcase

    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_ACQUIRE;
      miss_q       <= '0;
      err_cnt_q    <= '0;
      parity_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else if (clr) begin
      state_q      <= ST_ACQUIRE;
      miss_q       <= '0;
      err_cnt_q    <= '0;
      parity_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_q       <= miss_d;
      err_cnt_q    <= err_cnt_d;
      parity_err_q <= parity_err_d;
      seq_err_q    <= seq_err_d;
      fault_q      <= fault_d;
    end
  end

  assign parity_err = parity_err_q;
  assign seq_err    = seq_err_q;
  assign err_count  = err_cnt_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_guarded_counter_checker.sv
// Directed scoreboard bench for guarded_counter_checker; expectations follow
// CHECKER_SEQ_EN so the same bench covers both builds.
module tb_guarded_counter_checker;

`ifdef CHECKER_SEQ_EN
  localparam int SEQ = 1;
`else
  localparam int SEQ = 0;
`endif

  typedef struct packed {
    logic       pe;
    logic       se;
    logic [7:0] cnt;
    logic       flt;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn, clr, in_valid;
  logic [7:0] cnt_in;
  logic [3:0] even_in, odd_in;
  logic       parity_err, seq_err, fault;
  logic [7:0] err_count;
  logic [1:0] state;

  int   n_err = 0;
  int   n_checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  guarded_counter_checker #(
    .WIDTH(8), .GUARD_BITS(4), .ERR_CNT_W(8), .MAX_MISS(3)
  ) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid),
    .cnt_in(cnt_in), .even_in(even_in), .odd_in(odd_in),
    .parity_err(parity_err), .seq_err(seq_err), .err_count(err_count),
    .fault(fault), .state(state)
  );

  function automatic logic [3:0] pc(input logic [7:0] v, input int start);
    int c = 0;
    for (int i = start; i < 8; i += 2) c += int'(v[i]);
    return c[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: drive, push the expectation, clock, pop and compare.
  task automatic step(input string name, input logic v, input logic [7:0] val,
                      input logic badg, input logic c,
                      input logic epe, input logic ese, input logic [7:0] ecnt,
                      input logic eflt, input logic [1:0] est);
    exp_t e;
    clr      = c;
    in_valid = v;
    cnt_in   = val;
    even_in  = pc(val, 0);
    odd_in   = pc(val, 1) - {3'b0, badg};
    sb_q.push_back('{pe: epe, se: ese, cnt: ecnt, flt: eflt, st: est});
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check({name, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({name, " parity_err"}, 32'(parity_err), 32'(e.pe));
      check({name, " seq_err"},    32'(seq_err),    32'(e.se));
      check({name, " err_count"},  32'(err_count),  32'(e.cnt));
      check({name, " fault"},      32'(fault),      32'(e.flt));
      check({name, " state"},      32'(state),      32'(e.st));
    end
    $display("%s v=%0d clr=%0d cnt=%02h -> pe=%0d se=%0d ec=%0d f=%0d st=%0d",
             name, v, c, val, parity_err, seq_err, err_count, fault, state);
  endtask

  task automatic check_zero(input string name);
    check({name, " parity_err"}, 32'(parity_err), 32'd0);
    check({name, " seq_err"},    32'(seq_err),    32'd0);
    check({name, " err_count"},  32'(err_count),  32'd0);
    check({name, " fault"},      32'(fault),      32'd0);
    check({name, " state"},      32'(state),      32'd0);
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0;
    cnt_in = '0; even_in = '0; odd_in = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Full counting range plus the 255 -> 0 wrap, every cycle.
    for (int i = 0; i < 257; i++)
      step("count", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("idle", 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("trk_badg", 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'b01);
    step("trk_good", 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 2'b01);

    // 8'hFF with even=4, odd=3 as the seeding sample.
    step("clr1", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    step("ff_acq", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'b01);
    step("ff_next", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 2'b01);

    // Single corrupted value: 10, 11, 40, 13, 14.
    step("clr2", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    step("s10", 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("s11", 1'b1, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("s40", 1'b1, 8'd40, 1'b0, 1'b0, 1'b0, 1'(SEQ), 8'(SEQ), 1'b0, 2'b01);
    step("s13", 1'b1, 8'd13, 1'b0, 1'b0, 1'b0, 1'b0, 8'(SEQ), 1'b0, 2'b01);
    step("s14", 1'b1, 8'd14, 1'b0, 1'b0, 1'b0, 1'b0, 8'(SEQ), 1'b0, 2'b01);

    // Upstream reset mid-stream: 10, 11, 0, 1, 2, then a bad guard while faulted.
    step("clr3", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    step("u10", 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("u11", 1'b1, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("u0", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'(SEQ), 8'(SEQ), 1'b0, 2'b01);
    step("u1", 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'(SEQ), 8'(SEQ * 2), 1'b0, 2'b01);
    step("u2", 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'(SEQ), 8'(SEQ * 3), 1'(SEQ),
         (SEQ != 0) ? 2'b10 : 2'b01);
    step("u15_badg", 1'b1, 8'd15, 1'b1, 1'b0, 1'b1, 1'b0, 8'(SEQ * 3 + 1), 1'(SEQ),
         (SEQ != 0) ? 2'b10 : 2'b01);
    step("clr4", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    step("clr_sample", 1'b1, 8'd77, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);

    // Asynchronous reset while tracking, then re-seed from ACQUIRE.
    step("r10", 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("r11", 1'b1, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("r12_badg", 1'b1, 8'd12, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 2'b01);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    step("rs50", 1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);
    step("rs51", 1'b1, 8'd51, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01);

    // Run of bad guards: fault on the third, err_count saturates at 255.
    step("clr5", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    for (int i = 0; i < 260; i++)
      step("sat", 1'b1, 8'(i + 100), 1'b1, 1'b0, 1'b1, 1'b0,
           (i >= 254) ? 8'd255 : 8'(i + 1), 1'(i >= 2), (i >= 2) ? 2'b10 : 2'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
